// File: rtl/roc_decoder.sv
// Rank-order-code AER receiver: acknowledges events, detects SYNC,SYNC frame start, builds the rank map.
// Optional macro ROC_DECODER_INTENSITY_EN makes RD_DATA return an intensity estimate instead of the rank.
module roc_decoder #(
    parameter int unsigned IMAGE_SIZE      = 256,
    parameter int unsigned IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
    parameter int unsigned RANK_BITS       = IMAGE_SIZE_BITS + 1
`ifdef ROC_DECODER_INTENSITY_EN
    ,
    parameter int unsigned PIXEL_MAX_VALUE = 255
`endif
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [9:0]                 AERIN_ADDR,
    input  logic                       AERIN_REQ,
    output logic                       AERIN_ACK,
    input  logic                       FRAME_END,
    input  logic [IMAGE_SIZE_BITS-1:0] RD_ADDR,
    output logic [RANK_BITS-1:0]       RD_DATA,
    output logic [RANK_BITS-1:0]       RANK_COUNT,
    output logic                       DECODER_RDY,
    output logic                       FRAME_DONE,
    output logic                       ERR
);

    typedef enum logic {H_WAIT, H_ACK} h_state_t;
    typedef enum logic [1:0] {D_IDLE, D_ARMED, D_RUN, D_DONE} d_state_t;

    localparam logic [9:0] SYNC_ADDR = 10'h1FF;

    logic req_m, req_s;

    h_state_t h_state, h_next;
    logic     ack_next, evt_next, cap_c;
    logic     evt;
    logic [9:0] evt_addr;

    d_state_t d_state, d_next;
    logic     wr_c, clr_c, err_c;
    logic     is_sync_c, is_idx_c;
    logic [IMAGE_SIZE_BITS-1:0] idx_c;

    logic [IMAGE_SIZE-1:0] seen;
    logic [RANK_BITS-1:0]  map_mem [IMAGE_SIZE];
    logic [RANK_BITS-1:0]  rd_next;

    // Two-flop synchronizer for the asynchronous request
    always_ff @(posedge CLK) begin
        if (RST) begin
            req_m <= 1'b0;
            req_s <= 1'b0;
        end else begin
            req_m <= AERIN_REQ;
            req_s <= req_m;
        end
    end

    // Handshake FSM: one evt per request pulse
    always_comb begin
        h_next   = h_state;
        ack_next = AERIN_ACK;
        evt_next = 1'b0;
        cap_c    = 1'b0;
        case (h_state)
            H_WAIT: if (req_s) begin
                h_next   = H_ACK;
                ack_next = 1'b1;
                evt_next = 1'b1;
                cap_c    = 1'b1;
            end
            H_ACK: if (!req_s) begin
                h_next   = H_WAIT;
                ack_next = 1'b0;
            end
            default: begin
                h_next   = H_WAIT;
                ack_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            h_state   <= H_WAIT;
            AERIN_ACK <= 1'b0;
            evt       <= 1'b0;
            evt_addr  <= '0;
        end else begin
            h_state   <= h_next;
            AERIN_ACK <= ack_next;
            evt       <= evt_next;
            if (cap_c) evt_addr <= AERIN_ADDR;
        end
    end

    assign is_sync_c = (evt_addr == SYNC_ADDR);
    assign is_idx_c  = (evt_addr[9:8] == 2'b00) && (32'(evt_addr) < IMAGE_SIZE);
    assign idx_c     = evt_addr[IMAGE_SIZE_BITS-1:0];

    // Decode FSM next-state and frame control
    always_comb begin
        d_next = d_state;
        wr_c   = 1'b0;
        clr_c  = 1'b0;
        err_c  = 1'b0;
        case (d_state)
            D_IDLE: if (evt && is_sync_c) d_next = D_ARMED;
            D_ARMED: if (evt) begin
                if (is_sync_c) begin
                    d_next = D_RUN;
                    clr_c  = 1'b1;
                end else begin
                    d_next = D_IDLE;
                end
            end
            D_RUN: begin
                if (evt && is_sync_c) begin
                    d_next = D_ARMED;
                end else begin
                    if (evt && is_idx_c && !seen[idx_c] && (32'(RANK_COUNT) < IMAGE_SIZE))
                        wr_c = 1'b1;
                    else if (evt)
                        err_c = 1'b1;
                    // An event arriving with FRAME_END is recorded before the frame closes
                    if (FRAME_END || (wr_c && (32'(RANK_COUNT) + 32'd1 == IMAGE_SIZE)))
                        d_next = D_DONE;
                end
            end
            D_DONE:  d_next = D_IDLE;
            default: d_next = D_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            d_state     <= D_IDLE;
            RANK_COUNT  <= '0;
            ERR         <= 1'b0;
            seen        <= '0;
            DECODER_RDY <= 1'b1;
            FRAME_DONE  <= 1'b0;
        end else begin
            d_state     <= d_next;
            DECODER_RDY <= (d_next == D_IDLE);
            FRAME_DONE  <= (d_next == D_DONE);
            if (clr_c) begin
                seen       <= '0;
                RANK_COUNT <= '0;
                ERR        <= 1'b0;
            end
            if (wr_c) begin
                seen[idx_c] <= 1'b1;
                RANK_COUNT  <= RANK_COUNT + RANK_BITS'(1);
            end
            if (err_c) ERR <= 1'b1;
        end
    end

    // Map storage needs no reset; validity is tracked by the seen bits
    always_ff @(posedge CLK) begin
        if (!RST && wr_c) map_mem[idx_c] <= RANK_COUNT;
    end

    always_comb begin
        rd_next = '0;
`ifdef ROC_DECODER_INTENSITY_EN
        if (seen[RD_ADDR]) begin
            if (32'(map_mem[RD_ADDR]) >= PIXEL_MAX_VALUE)
                rd_next = '0;
            else
                rd_next = RANK_BITS'(PIXEL_MAX_VALUE - 32'(map_mem[RD_ADDR]));
        end
`else
        if (seen[RD_ADDR])
            rd_next = map_mem[RD_ADDR];
        else
            rd_next = RANK_BITS'(IMAGE_SIZE);
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) RD_DATA <= '0;
        else     RD_DATA <= rd_next;
    end

endmodule

// File: tb/tb_roc_decoder.sv
// Self-checking bench for roc_decoder: directed tables, handshake corner cases and a randomized model check.
module tb_roc_decoder;

    logic       CLK = 1'b0;
    logic       RST;
    logic [9:0] AERIN_ADDR;
    logic       AERIN_REQ;
    logic       AERIN_ACK;
    logic       FRAME_END;
    logic [7:0] RD_ADDR;
    logic [8:0] RD_DATA;
    logic [8:0] RANK_COUNT;
    logic       DECODER_RDY;
    logic       FRAME_DONE;
    logic       ERR;

    int pass_cnt = 0;
    int total_cnt = 0;
    int done_cnt = 0;

    // Reference model: arrival order of accepted indices plus frame flags
    int order[$];
    bit m_run = 0;
    bit m_armed = 0;
    bit m_err = 0;
    int m_done = 0;

    typedef struct {
        int addr;
        int raw;
    } rd_vec_t;

    roc_decoder dut (
        .CLK(CLK), .RST(RST), .AERIN_ADDR(AERIN_ADDR), .AERIN_REQ(AERIN_REQ),
        .AERIN_ACK(AERIN_ACK), .FRAME_END(FRAME_END), .RD_ADDR(RD_ADDR),
        .RD_DATA(RD_DATA), .RANK_COUNT(RANK_COUNT), .DECODER_RDY(DECODER_RDY),
        .FRAME_DONE(FRAME_DONE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (FRAME_DONE) done_cnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d required %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic int m_rank(input int a);
        foreach (order[i]) if (order[i] == a) return i;
        return 256;
    endfunction

    // Map a raw rank (256 = never fired) to what RD_DATA shows in this build
    function automatic int disp(input int raw);
`ifdef ROC_DECODER_INTENSITY_EN
        if (raw >= 256) return 0;
        return (raw >= 255) ? 0 : 255 - raw;
`else
        return raw;
`endif
    endfunction

    task automatic m_evt(input int a, input bit fe);
        if (m_run) begin
            if (a == 'h1FF) begin
                m_run = 0;
                m_armed = 1;
            end else begin
                if (a < 256 && m_rank(a) == 256) order.push_back(a);
                else m_err = 1;
                if (fe || order.size() == 256) begin
                    m_run = 0;
                    m_done++;
                end
            end
        end else if (m_armed) begin
            m_armed = 0;
            if (a == 'h1FF) begin
                m_run = 1;
                order.delete();
                m_err = 0;
            end
        end else if (a == 'h1FF) begin
            m_armed = 1;
        end
    endtask

    task automatic m_reset();
        order.delete();
        m_run = 0;
        m_armed = 0;
        m_err = 0;
    endtask

    task automatic send(input logic [9:0] a, input bit fe = 1'b0);
        int n;
        AERIN_ADDR = a;
        AERIN_REQ = 1'b1;
        n = 0;
        while (!AERIN_ACK && n < 20) begin tick(); n++; end
        chk("ack_rise", int'(AERIN_ACK), 1);
        if (fe) begin
            FRAME_END = 1'b1;
            tick();
            FRAME_END = 1'b0;
        end
        AERIN_REQ = 1'b0;
        n = 0;
        while (AERIN_ACK && n < 20) begin tick(); n++; end
        chk("ack_fall", int'(AERIN_ACK), 0);
        tick();
        m_evt(int'(a), fe);
    endtask

    task automatic fe_pulse();
        FRAME_END = 1'b1;
        tick();
        FRAME_END = 1'b0;
        tick();
        tick();
        if (m_run) begin
            m_run = 0;
            m_done++;
        end
    endtask

    task automatic rd(input int a, output int v);
        RD_ADDR = 8'(a);
        tick();
        v = int'(RD_DATA);
    endtask

    task automatic sync2();
        send(10'h1FF);
        send(10'h1FF);
    endtask

    initial begin
        int v, d0, a1, a2, a3;
        logic [9:0] ra;
        rd_vec_t t1[4];
        t1 = '{'{5, 0}, '{3, 1}, '{7, 2}, '{0, 256}};

        RST = 1'b1; AERIN_ADDR = '0; AERIN_REQ = 1'b0; FRAME_END = 1'b0; RD_ADDR = '0;
        repeat (3) tick();
        chk("rst_ack", int'(AERIN_ACK), 0);
        chk("rst_rd_data", int'(RD_DATA), 0);
        chk("rst_rank_count", int'(RANK_COUNT), 0);
        chk("rst_rdy", int'(DECODER_RDY), 1);
        chk("rst_frame_done", int'(FRAME_DONE), 0);
        chk("rst_err", int'(ERR), 0);
        RST = 1'b0;
        tick();

        // Basic frame closed by FRAME_END
        sync2();
        chk("armed_rdy_low", int'(DECODER_RDY), 0);
        send(10'h005); send(10'h003); send(10'h007);
        fe_pulse();
        chk("t1_done_pulses", done_cnt, 1);
        chk("t1_rank_count", int'(RANK_COUNT), 3);
        chk("t1_err", int'(ERR), 0);
        chk("t1_rdy", int'(DECODER_RDY), 1);
        for (int i = 0; i < 4; i++) begin
            rd(t1[i].addr, v);
            chk($sformatf("t1_rd_%0d", t1[i].addr), v, disp(t1[i].raw));
        end

        // Full frame ends itself on the 256th index
        d0 = done_cnt;
        sync2();
        for (int i = 255; i >= 0; i--) send(10'(i));
        chk("full_done", done_cnt - d0, 1);
        chk("full_rank_count", int'(RANK_COUNT), 256);
        chk("full_rdy", int'(DECODER_RDY), 1);
        rd(255, v); chk("full_rd_255", v, disp(0));
        rd(0, v);   chk("full_rd_0", v, disp(255));
        rd(128, v); chk("full_rd_128", v, disp(127));

        // Duplicate and bad events inside RUN
        sync2();
        send(10'h009); send(10'h009); send(10'h2A5);
        chk("err_rank_count", int'(RANK_COUNT), 1);
        chk("err_flag", int'(ERR), 1);
        rd(9, v); chk("err_rd_9", v, disp(0));
        sync2();
        chk("err_cleared", int'(ERR), 0);
        rd(9, v); chk("err_rd_9_cleared", v, disp(256));
        fe_pulse();

        // Events outside a frame
        send(10'h004);
        chk("oof_idle_rdy", int'(DECODER_RDY), 1);
        send(10'h1FF);
        chk("oof_armed_rdy", int'(DECODER_RDY), 0);
        send(10'h004);
        chk("oof_back_idle", int'(DECODER_RDY), 1);
        sync2();
        send(10'h004);
        rd(4, v); chk("oof_rd_4", v, disp(0));

        // Long request: ACK timing and a single event
        AERIN_ADDR = 10'h010;
        AERIN_REQ = 1'b1;
        tick(); a1 = int'(AERIN_ACK);
        tick(); a2 = int'(AERIN_ACK);
        tick(); a3 = int'(AERIN_ACK);
        chk("hs_ack_edge1", a1, 0);
        chk("hs_ack_edge2", a2, 0);
        chk("hs_ack_edge3", a3, 1);
        repeat (7) tick();
        AERIN_REQ = 1'b0;
        tick(); a1 = int'(AERIN_ACK);
        tick(); a2 = int'(AERIN_ACK);
        tick(); a3 = int'(AERIN_ACK);
        chk("hs_hold_1", a1, 1);
        chk("hs_hold_2", a2, 1);
        chk("hs_drop_3", a3, 0);
        m_evt('h010, 0);
        chk("hs_rank_count", int'(RANK_COUNT), 2);
        rd('h10, v); chk("hs_rd_16", v, disp(1));

        // FRAME_END on the same cycle as an index event
        d0 = done_cnt;
        send(10'h020, 1'b1);
        chk("fe_coinc_done", done_cnt - d0, 1);
        chk("fe_coinc_count", int'(RANK_COUNT), 3);
        rd('h20, v); chk("fe_coinc_rd", v, disp(2));

        // Reset mid-frame
        sync2();
        send(10'd20); send(10'd21);
        RST = 1'b1; tick(); tick(); RST = 1'b0; tick();
        m_reset();
        chk("rst_run_ack", int'(AERIN_ACK), 0);
        chk("rst_run_rdy", int'(DECODER_RDY), 1);
        chk("rst_run_count", int'(RANK_COUNT), 0);
        rd(20, v); chk("rst_run_rd_20", v, disp(256));
        rd(21, v); chk("rst_run_rd_21", v, disp(256));

        // Reset mid-handshake
        sync2();
        AERIN_ADDR = 10'h030;
        AERIN_REQ = 1'b1;
        for (int n = 0; n < 20 && !AERIN_ACK; n++) tick();
        chk("rst_hs_ack_up", int'(AERIN_ACK), 1);
        RST = 1'b1; AERIN_REQ = 1'b0;
        tick();
        chk("rst_hs_ack_drop", int'(AERIN_ACK), 0);
        RST = 1'b0;
        repeat (3) tick();
        m_reset();
        chk("rst_hs_rdy", int'(DECODER_RDY), 1);
        rd('h30, v); chk("rst_hs_rd", v, disp(256));

        // Randomized frames against the reference model
        for (int f = 0; f < 5; f++) begin
            int nev;
            bit end_fe;
            sync2();
            nev = $urandom_range(10, 30);
            end_fe = ($urandom_range(0, 1) == 1);
            for (int e = 0; e < nev; e++) begin
                int r;
                r = $urandom_range(0, 99);
                if (r < 75)      ra = 10'($urandom_range(0, 63));
                else if (r < 90) ra = 10'h300 | 10'($urandom_range(0, 255));
                else             ra = 10'h1FF;
                send(ra, end_fe && (e == nev - 1));
            end
            chk($sformatf("rnd%0d_count", f), int'(RANK_COUNT), order.size());
            chk($sformatf("rnd%0d_err", f), int'(ERR), int'(m_err));
            chk($sformatf("rnd%0d_rdy", f), int'(DECODER_RDY), int'(!m_run && !m_armed));
            chk($sformatf("rnd%0d_done", f), done_cnt, m_done);
            for (int k = 0; k < 6; k++) begin
                int a;
                a = $urandom_range(0, 63);
                rd(a, v);
                chk($sformatf("rnd%0d_rd_%0d", f, a), v, disp(m_rank(a)));
            end
            if (m_run) fe_pulse();
        end
        chk("final_done", done_cnt, m_done);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
